// File: rtl/riscv_instr_fetch_ctrl_if.sv
// Instruction-memory request/response bus plus the fetch-FIFO push port of riscv_instr_fetch_ctrl.
// With FETCH_DIFT_TAG_EN defined, a 4-bit response tag travels from memory to the FIFO.
interface riscv_instr_fetch_ctrl_if;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic        fifo_ready_i;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
`ifdef FETCH_DIFT_TAG_EN
  logic [3:0]  instr_rtag_i;
  logic [3:0]  fifo_rtag_o;
`endif

  modport master (
    output fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o, instr_req_o, instr_addr_o,
    input  fifo_ready_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i
`ifdef FETCH_DIFT_TAG_EN
    , input instr_rtag_i, output fifo_rtag_o
`endif
  );

  modport slave (
    input  fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o, instr_req_o, instr_addr_o,
    output fifo_ready_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i
`ifdef FETCH_DIFT_TAG_EN
    , output instr_rtag_i, input fifo_rtag_o
`endif
  );
endinterface

// File: rtl/riscv_instr_fetch_ctrl.sv
// Fetch producer: issues word-aligned instruction requests, squashes redirected responses and
// buffers surviving words for the fetch FIFO. Optional response tag via FETCH_DIFT_TAG_EN.
module riscv_instr_fetch_ctrl #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fetch_enable_i,
  input  logic                            branch_i,
  input  logic [31:0]                     branch_addr_i,
  output logic                            busy_o,
  riscv_instr_fetch_ctrl_if.master        bus
);
  localparam int               PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]       MAX_CNT   = 3'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       discard_q, discard_d;
  logic [2:0]       buf_count_q, buf_count_d;
  logic             stale_hold_q, stale_hold_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      resp_addr_q, resp_addr_d;
  logic [31:0]      hold_addr_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

  logic [31:0]      buf_addr  [MAX_OUTSTANDING];
  logic [31:0]      buf_rdata [MAX_OUTSTANDING];
`ifdef FETCH_DIFT_TAG_EN
  logic [3:0]       buf_rtag  [MAX_OUTSTANDING];
`endif

  logic credit, req, gnt_ev, rvalid_ev, push, pop, buf_empty;
  logic unused_addr_bit0;

  assign unused_addr_bit0 = branch_addr_i[0];

  function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Words already in the buffer count against credit so every response always has a slot.
  assign buf_empty = (buf_count_q == '0);
  assign credit    = ({1'b0, pending_q} + {1'b0, buf_count_q}) < {1'b0, MAX_CNT};

  always_comb begin
    req = 1'b0;
    case (state_q)
      ISSUE:   req = credit & fetch_enable_i & ~branch_i;
      HOLD:    req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  assign gnt_ev    = req & bus.instr_gnt_i;
  assign rvalid_ev = bus.instr_rvalid_i & (pending_q != '0);
  assign push      = rvalid_ev & (discard_q == '0) & ~branch_i;
  assign pop       = ~buf_empty & bus.fifo_ready_i & ~branch_i;
  assign pending_d = pending_q + 3'(gnt_ev) - 3'(rvalid_ev);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (branch_i || fetch_enable_i) state_d = ISSUE;
      ISSUE: begin
        if (req && !bus.instr_gnt_i)                state_d = HOLD;
        else if (!fetch_enable_i && !branch_i)      state_d = IDLE;
      end
      HOLD:    if (bus.instr_gnt_i) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // A held request that outlives a branch is still counted as stale when it is finally granted.
  always_comb begin
    discard_d    = discard_q;
    stale_hold_d = stale_hold_q;
    if (gnt_ev) stale_hold_d = 1'b0;
    if (branch_i) begin
      discard_d = pending_d;
      if (state_q == HOLD && !gnt_ev) stale_hold_d = 1'b1;
    end else begin
      if (rvalid_ev && discard_q != '0) discard_d = discard_d - 3'd1;
      if (gnt_ev && stale_hold_q)       discard_d = discard_d + 3'd1;
    end
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    resp_addr_d  = resp_addr_q;
    if (branch_i) begin
      fetch_addr_d = {branch_addr_i[31:2], 2'b00};
      resp_addr_d  = {branch_addr_i[31:1], 1'b0};
    end else begin
      if (gnt_ev && !stale_hold_q) fetch_addr_d = fetch_addr_q + 32'd4;
      if (push)                    resp_addr_d  = {resp_addr_q[31:2], 2'b00} + 32'd4;
    end
  end

  always_comb begin
    buf_count_d = buf_count_q + 3'(push) - 3'(pop);
    if (branch_i) buf_count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      discard_q    <= '0;
      buf_count_q  <= '0;
      stale_hold_q <= 1'b0;
      fetch_addr_q <= '0;
      resp_addr_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      discard_q    <= discard_d;
      buf_count_q  <= buf_count_d;
      stale_hold_q <= stale_hold_d;
      fetch_addr_q <= fetch_addr_d;
      resp_addr_q  <= resp_addr_d;
      if (branch_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= next_slot(wr_ptr_q);
        if (pop)  rd_ptr_q <= next_slot(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ISSUE && req && !bus.instr_gnt_i) hold_addr_q <= fetch_addr_q;
    if (push) begin
      buf_addr[wr_ptr_q]  <= resp_addr_q;
      buf_rdata[wr_ptr_q] <= bus.instr_rdata_i;
`ifdef FETCH_DIFT_TAG_EN
      buf_rtag[wr_ptr_q]  <= bus.instr_rtag_i;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.instr_rvalid_i && pending_q == '0))
        else $error("instr_rvalid_i with no outstanding request");
    end
  end

  assign bus.instr_req_o  = req;
  assign bus.instr_addr_o = (state_q == HOLD) ? hold_addr_q : fetch_addr_q;
  assign bus.fifo_clear_o = branch_i;
  assign bus.fifo_valid_o = ~buf_empty;
  assign bus.fifo_addr_o  = buf_empty ? '0 : buf_addr[rd_ptr_q];
  assign bus.fifo_rdata_o = buf_empty ? '0 : buf_rdata[rd_ptr_q];
`ifdef FETCH_DIFT_TAG_EN
  assign bus.fifo_rtag_o  = buf_empty ? '0 : buf_rtag[rd_ptr_q];
`endif
  assign busy_o = (pending_q != '0) | (state_q == HOLD) | ~buf_empty;
endmodule

// File: tb/tb_riscv_instr_fetch_ctrl.sv
// Directed bench for riscv_instr_fetch_ctrl: the bench plays instruction memory and fetch FIFO.
module tb_riscv_instr_fetch_ctrl;
  logic        clk;
  logic        rst_n;
  logic        fetch_enable_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        busy_o;

  riscv_instr_fetch_ctrl_if bus();

  riscv_instr_fetch_ctrl #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_enable_i (fetch_enable_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .busy_o         (busy_o),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] D0 = 32'hA0A0_0001, D1 = 32'hA0A0_0002, D2 = 32'hB1B1_0003;
  localparam logic [31:0] D3 = 32'hB1B1_0004, D4 = 32'hC2C2_0005, D5 = 32'hD3D3_0006;
  localparam logic [31:0] E0 = 32'hE0E0_0007, E1 = 32'hE1E1_0008;
  localparam logic [31:0] W0 = 32'hF0F0_0009, W1 = 32'hF1F1_000A;
  localparam logic [31:0] BAD0 = 32'hDEAD_0000, BAD1 = 32'hDEAD_0001, BAD2 = 32'hDEAD_0002;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic en, input logic br, input logic [31:0] ba, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    fetch_enable_i     = en;
    branch_i           = br;
    branch_addr_i      = ba;
    bus.instr_gnt_i    = gnt;
    bus.instr_rvalid_i = rv;
    bus.instr_rdata_i  = rd;
    bus.fifo_ready_i   = rdy;
    #1;
  endtask

  task automatic chk_fifo(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_valid"}, 32'(bus.fifo_valid_o), 32'd1);
    chk({tag, "_addr"},  bus.fifo_addr_o, addr);
    chk({tag, "_rdata"}, bus.fifo_rdata_o, data);
  endtask

  initial begin
    rst_n              = 1'b0;
    fetch_enable_i     = 1'b0;
    branch_i           = 1'b0;
    branch_addr_i      = '0;
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i  = '0;
    bus.fifo_ready_i   = 1'b0;

    // Reset
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_req",   32'(bus.instr_req_o),  32'd0);
    chk("rst_iaddr", bus.instr_addr_o,      32'd0);
    chk("rst_valid", 32'(bus.fifo_valid_o), 32'd0);
    chk("rst_faddr", bus.fifo_addr_o,       32'd0);
    chk("rst_rdata", bus.fifo_rdata_o,      32'd0);
    chk("rst_clear", 32'(bus.fifo_clear_o), 32'd0);
    chk("rst_busy",  32'(busy_o),           32'd0);
    rst_n = 1'b1;

    // Branch to 0x100, two words
    drive(1, 1, 32'h100, 0, 0, 0, 0);
    chk("t1_clear", 32'(bus.fifo_clear_o), 32'd1);
    chk("t1_req0",  32'(bus.instr_req_o),  32'd0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t1_req1",  32'(bus.instr_req_o),  32'd1);
    chk("t1_addr1", bus.instr_addr_o,      32'h100);
    chk("t1_clr1",  32'(bus.fifo_clear_o), 32'd0);
    chk("t1_nov",   32'(bus.fifo_valid_o), 32'd0);
    drive(1, 0, 0, 1, 1, D0, 0);
    chk("t1_addr2", bus.instr_addr_o,      32'h104);
    drive(0, 0, 0, 0, 1, D1, 1);
    chk_fifo("t1_w0", 32'h100, D0);
    chk("t1_req_off", 32'(bus.instr_req_o), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_fifo("t1_w1", 32'h104, D1);
    chk("t1_busy",  32'(busy_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t1_empty", 32'(bus.fifo_valid_o), 32'd0);
    chk("t1_idle",  32'(busy_o), 32'd0);

    // Halfword-unaligned branch to 0x202
    drive(1, 1, 32'h202, 0, 0, 0, 0);
    chk("t2_clear", 32'(bus.fifo_clear_o), 32'd1);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t2_addr1", bus.instr_addr_o,      32'h200);
    chk("t2_clr1",  32'(bus.fifo_clear_o), 32'd0);
    drive(1, 0, 0, 1, 1, D2, 0);
    chk("t2_addr2", bus.instr_addr_o,      32'h204);
    drive(0, 0, 0, 0, 1, D3, 1);
    chk_fifo("t2_w0", 32'h202, D2);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_fifo("t2_w1", 32'h204, D3);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t2_empty", 32'(bus.fifo_valid_o), 32'd0);

    // Two requests in flight, branch to 0x400 squashes both responses
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t3_idle_req", 32'(bus.instr_req_o), 32'd0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t3_addr1", bus.instr_addr_o, 32'h208);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t3_addr2", bus.instr_addr_o, 32'h20C);
    chk("t3_req2",  32'(bus.instr_req_o), 32'd1);
    drive(1, 1, 32'h400, 0, 1, BAD0, 0);
    chk("t3_nocredit", 32'(bus.instr_req_o),  32'd0);
    chk("t3_clear",    32'(bus.fifo_clear_o), 32'd1);
    drive(1, 0, 0, 1, 1, BAD1, 0);
    chk("t3_req_tgt",  32'(bus.instr_req_o), 32'd1);
    chk("t3_addr_tgt", bus.instr_addr_o,     32'h400);
    chk("t3_drop0",    32'(bus.fifo_valid_o), 32'd0);
    drive(0, 0, 0, 0, 1, D4, 0);
    chk("t3_drop1",    32'(bus.fifo_valid_o), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_fifo("t3_w0", 32'h400, D4);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t3_empty", 32'(bus.fifo_valid_o), 32'd0);
    chk("t3_idle",  32'(busy_o), 32'd0);

    // Grant withheld 3 cycles, branch to 0x800 in the second
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t4_h1", bus.instr_addr_o, 32'h404);
    drive(1, 1, 32'h800, 0, 0, 0, 0);
    chk("t4_h2",     bus.instr_addr_o,      32'h404);
    chk("t4_h2_req", 32'(bus.instr_req_o),  32'd1);
    chk("t4_clear",  32'(bus.fifo_clear_o), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t4_h3",     bus.instr_addr_o,      32'h404);
    chk("t4_busy",   32'(busy_o),           32'd1);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t4_gnt",    bus.instr_addr_o,      32'h404);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t4_tgt",    bus.instr_addr_o,      32'h800);
    chk("t4_tgt_req", 32'(bus.instr_req_o), 32'd1);
    drive(0, 0, 0, 0, 1, BAD2, 0);
    chk("t4_req_off", 32'(bus.instr_req_o), 32'd0);
    drive(0, 0, 0, 0, 1, D5, 0);
    chk("t4_drop",   32'(bus.fifo_valid_o), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_fifo("t4_w0", 32'h800, D5);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t4_empty", 32'(bus.fifo_valid_o), 32'd0);
    chk("t4_idle",  32'(busy_o), 32'd0);

    // FIFO stalled for 6 cycles: credit caps traffic at 2 words
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t5_addr1", bus.instr_addr_o, 32'h804);
    drive(1, 0, 0, 1, 1, E0, 0);
    chk("t5_addr2", bus.instr_addr_o, 32'h808);
    chk("t5_req2",  32'(bus.instr_req_o), 32'd1);
    drive(1, 0, 0, 0, 1, E1, 0);
    chk("t5_cap0",  32'(bus.instr_req_o), 32'd0);
    chk_fifo("t5_hold0", 32'h804, E0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t5_cap1",  32'(bus.instr_req_o), 32'd0);
    chk_fifo("t5_hold1", 32'h804, E0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t5_cap2",  32'(bus.instr_req_o), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 1);
    chk_fifo("t5_w0", 32'h804, E0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_fifo("t5_w1", 32'h808, E1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t5_empty", 32'(bus.fifo_valid_o), 32'd0);
    chk("t5_idle",  32'(busy_o), 32'd0);

    // Address wrap at the top of memory, then drain to idle
    drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t6_top",  bus.instr_addr_o, 32'hFFFF_FFFC);
    drive(1, 0, 0, 1, 1, W0, 0);
    chk("t6_wrap", bus.instr_addr_o, 32'h0000_0000);
    drive(0, 0, 0, 0, 1, W1, 1);
    chk_fifo("t6_w0", 32'hFFFF_FFFC, W0);
    chk("t6_busy", 32'(busy_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_fifo("t6_w1", 32'h0000_0000, W1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t6_empty", 32'(bus.fifo_valid_o), 32'd0);
    chk("t6_idle",  32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_instr_fetch_ctrl.md
Name: riscv_instr_fetch_ctrl

Overview:
Instruction-memory-side producer for the fetch FIFO. It issues word-aligned requests on the instruction memory interface (req/gnt/rvalid), tracks outstanding transactions and squashes responses from redirected fetches. Surviving words are pushed, each with its fetch address, into the fetch FIFO's input port (addr/rdata/valid/ready). On a branch it clears the FIFO and restarts fetching, including at halfword-unaligned targets.

Parameters:
MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests plus buffered words; legal range 1..4.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
fetch_enable_i  in  1  permits issuing new requests
branch_i  in  1  redirect fetch this cycle
branch_addr_i  in  32  redirect target; bit1 may be set, bit0 ignored
fifo_clear_o  out  1  clears fetch FIFO contents
fifo_valid_o  out  1  word available to FIFO
fifo_ready_i  in  1  FIFO accepts word
fifo_addr_o  out  32  address of word (first word after branch carries target bit1)
fifo_rdata_o  out  32  instruction word
instr_req_o  out  1  memory request
instr_addr_o  out  32  request address, bits[1:0]=00
instr_gnt_i  in  1  request granted
instr_rvalid_i  in  1  response valid (cannot be back-pressured)
instr_rdata_i  in  32  response data
busy_o  out  1  pending, held or buffered traffic exists

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0; state IDLE; pending_q=0, discard_q=0, buffer empty, fetch_addr_q=0, resp_addr_q=0.
- States:
  - IDLE: no request.
  - ISSUE: request asserted if credit available.
  - HOLD: request asserted, not yet granted.
- Transitions:
  - IDLE->ISSUE on branch_i or fetch_enable_i.
  - ISSUE->HOLD when instr_req_o=1 and instr_gnt_i=0.
  - HOLD->ISSUE on gnt.
  - ISSUE->IDLE when fetch_enable_i=0 and no branch.
- Credit: pending_q + buf_count + (rvalid this cycle ? 0 : 0) < MAX_OUTSTANDING; buf_count is the local response buffer occupancy (depth MAX_OUTSTANDING). Guarantees every rvalid finds space.
- HOLD: instr_req_o stays 1 and instr_addr_o stays stable until gnt, regardless of branch, fetch_enable_i or credit. A request never retracts.
- On gnt: pending_q++. fetch_addr_q += 4, wrapping 0xFFFFFFFC->0x00000000.
- On rvalid: pending_q--.
  - If discard_q>0: data dropped, discard_q--.
  - Else: {resp_addr_q, rdata} written to buffer tail; resp_addr_q <= {resp_addr_q[31:2],2'b00}+4.
  - rvalid with pending_q=0 is a protocol error: ignored, assertion fires.
- Simultaneous gnt and rvalid in one cycle: pending_q unchanged.
- Output: fifo_valid_o = buffer non-empty; head presented from flops (latency rvalid->fifo_valid_o = 1 cycle). Pop on fifo_valid_o & fifo_ready_i.
- Branch (branch_i=1), all in the same cycle:
  - fifo_clear_o=1 combinationally.
  - Buffer flushed next cycle; a push and a pop in the branch cycle are both void.
  - discard_q <= pending_q after this cycle's gnt/rvalid update (rvalid in the branch cycle is dropped).
  - If a request is held in HOLD, a stale_hold flag is set; its grant adds one to discard_q.
  - fetch_addr_q <= {branch_addr_i[31:2],2'b00}; resp_addr_q <= {branch_addr_i[31:1],1'b0}.
  - First request to the target may be issued the cycle after the branch, or after the held request is granted.
- Branch with fetch_enable_i=0: redirect, clear and squash still apply; requests issue only once enabled.
- Back-to-back branches: the latest target wins; discard_q accumulates correctly.
- busy_o = (pending_q!=0) | (state==HOLD) | buffer non-empty.

Optional Feature:
FETCH_DIFT_TAG_EN:
- Defined: adds ports instr_rtag_i in 4 and fifo_rtag_o out 4. Tag is stored in the buffer alongside rdata and follows the same push, pop, flush and discard rules. fifo_rtag_o resets to 0.
- Undefined: ports absent, no tag storage.

Test Plan:
- Reset, fetch_enable_i=1, branch to 0x100, gnt same cycle, rvalid 1 cycle later -> requests 0x100,0x104; FIFO receives (0x100,data0) then (0x104,data1); fifo_valid_o 1 cycle after each rvalid.
- Branch to 0x202 -> instr_addr_o=0x200; first fifo_addr_o=0x202, next 0x204; fifo_clear_o=1 only in the branch cycle.
- 2 requests pending, branch to 0x400 -> both responses dropped (no fifo_valid_o); first pushed word has address 0x400.
- gnt held low 3 cycles with branch in cycle 2 -> instr_addr_o stable at old address until gnt; that response dropped; next request goes to the branch target.
- fifo_ready_i=0 for 6 cycles -> at most MAX_OUTSTANDING (2) words in flight or buffered; no response lost; words delivered in order on release.
- fetch_addr 0xFFFFFFFC -> next request 0x00000000; busy_o falls to 0 once fetch_enable_i=0 and all responses are drained.
